// File: rtl/multi_key_ctrl.sv
// Multi-key debounce controller: per-key synchroniser, debounce, press/release
// edge pulses and long-press auto-repeat, plus a 4-way direction decoder fed
// by the first four channels.

// One key channel: sync -> normalise -> debounce -> edge pulses -> repeat FSM
module multi_key_lane #(
    parameter int CNT_MAX    = 999_999,
    parameter int REPEAT_DLY = 24_999_999,
    parameter int REPEAT_PER = 4_999_999,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int CW   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
    localparam logic [RW-1:0] DLY_TOP = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] PER_TOP = RW'(REPEAT_PER);
    localparam logic          REL_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {IDLE, HOLD_DLY, REPEAT} rpt_state_t;

    logic          sync1, sync2, samp;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    rpt_state_t    state;
    logic          differs, flip, press_ev, rel_ev;

    assign differs  = (samp != level);
    assign flip     = differs && (cnt == CNT_TOP);
    assign press_ev = flip && !level;
    assign rel_ev   = flip && level;

    // Two-flop synchroniser plus a normalising register (1 = pressed);
    // the extra register sets the debounce latency to CNT_MAX+3 edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
            samp  <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            samp  <= ACTIVE_LOW ? ~sync2 : sync2;
        end
    end

    // Debounce counter; level toggles once the new value has held CNT_MAX+1 samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= press_ev;
            rel   <= rel_ev;
            if (!differs) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Auto-repeat FSM, armed only by a press seen while repeat_en is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (rel_ev || !repeat_en) begin
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press_ev) begin
                            state <= HOLD_DLY;
                            rcnt  <= '0;
                        end
                    end
                    HOLD_DLY: begin
                        if (rcnt == DLY_TOP) begin
                            rpt   <= 1'b1;
                            state <= REPEAT;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt == PER_TOP) begin
                            rpt  <= 1'b1;
                            rcnt <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module multi_key_ctrl #(
    parameter int N_KEYS     = 4,
    parameter int CNT_MAX    = 999_999,
    parameter int REPEAT_DLY = 24_999_999,
    parameter int REPEAT_PER = 4_999_999,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              repeat_en,
    input  logic              dir_load,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_press,
    output logic [1:0]        dir_code,
    output logic              dir_valid
);
    logic       req_vld;
    logic [1:0] req_code;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        multi_key_lane #(
            .CNT_MAX   (CNT_MAX),
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_raw  (key_in[g]),
            .repeat_en(repeat_en),
            .level    (key_level[g]),
            .press    (key_press[g]),
            .rel      (key_release[g]),
            .rpt      (key_repeat[g])
        );
    end

    assign any_press = |key_press;

    // Pick the lowest-index press among channels 0..3 that is not the
    // reverse of the current direction (reverse = code with bit 0 flipped)
    always_comb begin
        req_vld  = 1'b0;
        req_code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_press[i] && (2'(i) != (dir_code ^ 2'b01))) begin
                req_vld  = 1'b1;
                req_code = 2'(i);
            end
        end
    end

    // Direction register; dir_load overrides any request and gives no pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_code  <= 2'd0;
            dir_valid <= 1'b0;
        end else begin
            dir_valid <= 1'b0;
            if (dir_load) begin
                dir_code <= 2'd0;
            end else if (req_vld) begin
                dir_code  <= req_code;
                dir_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/multi_key_ctrl.md
MULTI_KEY_CTRL -- requirements
Module: multi_key_ctrl

Interface
REQ-001 The block SHALL have these parameters: N_KEYS, default 4, number of key channels, minimum 4. CNT_MAX, default 999_999, debounce count (20 ms at 50 MHz). REPEAT_DLY, default 24_999_999, hold time before the first repeat. REPEAT_PER, default 4_999_999, interval between repeats. ACTIVE_LOW, default 1; 1 means a pressed key reads 0.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  N_KEYS  raw, unsynchronised key levels.
- repeat_en  in  1  enables long-press auto-repeat.
- dir_load  in  1  one-cycle request to force the direction to right.
- key_level  out  N_KEYS  debounced level; 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse on a debounced press.
- key_release  out  N_KEYS  one-cycle pulse on a debounced release.
- key_repeat  out  N_KEYS  one-cycle auto-repeat pulse.
- any_press  out  1  OR of key_press.
- dir_code  out  2  current direction: 0 right, 1 left, 2 down, 3 up.
- dir_valid  out  1  one-cycle pulse when a direction request is accepted.

Function
REQ-003 Each key_in bit SHALL pass through a 2-flop synchroniser whose flops hold the released level.
REQ-004 The normalised sample SHALL be 1 for pressed: ~sync when ACTIVE_LOW=1, sync otherwise.
REQ-005 Each channel SHALL have a counter of width $clog2(CNT_MAX+1), updated as follows:
- cleared when the sample equals key_level;
- incremented when the sample differs;
- when the sample differs and the counter equals CNT_MAX, key_level SHALL toggle and the counter SHALL clear.
REQ-006 Debounce latency: key_level SHALL change exactly CNT_MAX+3 edges after the first edge that samples a stable new raw level. Any shorter glitch SHALL produce no change and no pulse.
REQ-007 key_press[i] and key_release[i] SHALL be asserted on the same edge on which key_level[i] updates, for exactly one cycle.
REQ-008 any_press SHALL equal the OR of key_press in the same cycle.
REQ-009 Each channel SHALL have a repeat FSM with states IDLE, HOLD_DLY and REPEAT, and a counter sized for max(REPEAT_DLY, REPEAT_PER).
REQ-010 Repeat FSM behaviour:
- On key_press with repeat_en=1: IDLE -> HOLD_DLY, counter=0.
- In HOLD_DLY: when counter==REPEAT_DLY, pulse key_repeat, go to REPEAT, counter=0; otherwise increment.
- In REPEAT: when counter==REPEAT_PER, pulse key_repeat, counter=0; otherwise increment.
REQ-011 A debounced release SHALL force IDLE from any state, with no key_repeat in that cycle.
REQ-012 repeat_en=0 SHALL force IDLE and suppress key_repeat. A key pressed while repeat_en=0 SHALL NOT arm repeat later.
REQ-013 Channels 0..3 SHALL map to directions right, left, down and up; channels 4 and above SHALL NOT affect direction.
REQ-014 A direction request SHALL come from key_press[0..3] only; key_repeat SHALL NOT generate requests.
REQ-015 Opposite pairs (0/1, 2/3) of the current dir_code SHALL be rejected.
REQ-016 Among pressed channels that are not rejected, the lowest index SHALL win. A request equal to the current direction SHALL be accepted and produce a pulse with no code change.
REQ-017 On acceptance, dir_code SHALL update and dir_valid SHALL pulse one edge after the key_press pulse. When all requests are rejected, there SHALL be no pulse and no change.
REQ-018 dir_load=1 SHALL set dir_code=0 on the next edge with no dir_valid pulse, and SHALL take priority over a simultaneous request.
REQ-019 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses.

Reset
REQ-020 rst_n low SHALL immediately (asynchronously) set the following:
- key_level=0 and all pulse outputs 0;
- dir_code=0, dir_valid=0;
- all counters 0;
- FSMs to IDLE;
- synchroniser flops to the released level.
REQ-021 A key held across reset release SHALL be reported as a fresh press after CNT_MAX+3 edges.

Verification (CNT_MAX=3, REPEAT_DLY=9, REPEAT_PER=4, ACTIVE_LOW=1)
REQ-022 Glitch: key_in[0] low for 2 cycles, then high -> key_level[0] stays 0, no pulses.
REQ-023 Clean press: key_in[0] low, held, first sampled at edge 0 -> key_level[0]=1 and key_press[0]=1 at edge 6 only, dir_valid pulse at edge 7, dir_code stays 0.
REQ-024 Repeat: key_press[1] at edge p with dir_code=3 and repeat_en=1 -> key_repeat[1] at p+10, p+15 and p+20. Releasing the key or dropping repeat_en stops the pulses.
REQ-025 Reversal: dir_code=0, press key 1 -> no dir_valid, code 0. Press key 3 -> dir_valid, code 3. Press key 2 -> rejected, code 3.
REQ-026 Simultaneous press: with dir_code=3, key_press[0] and key_press[2] on the same edge -> dir_code=0 with one dir_valid. dir_load asserted on that same edge -> dir_code=0 with no dir_valid.
REQ-027 Reset mid-repeat: rst_n low while key 0 is in REPEAT -> all outputs 0 at once. After release with the key still held, key_press[0] at edge 6.
